// File: rtl/regfile_mp_if.sv
// Register file port bundle: read/issue side from ID, write/clear side from EX/MEM.
interface regfile_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 2
);
   logic [NRD*ADDR_W-1:0] rd_addr_i;
   logic [NRD*DATA_W-1:0] rd_data_o;
   logic [NRD-1:0]        rd_ready_o;
   logic [NRD-1:0]        rd_used_i;
   logic                  stall_o;
   logic [NWR-1:0]        wr_en_i;
   logic [NWR*ADDR_W-1:0] wr_addr_i;
   logic [NWR*DATA_W-1:0] wr_data_i;
   logic [NWR-1:0]        wr_clr_i;
   logic                  iss_en_i;
   logic [ADDR_W-1:0]     iss_rd_i;
   logic                  flush_i;

   // Pipeline side drives requests and consumes read results
   modport master (
      output rd_addr_i, rd_used_i, wr_en_i, wr_addr_i, wr_data_i, wr_clr_i,
             iss_en_i, iss_rd_i, flush_i,
      input  rd_data_o, rd_ready_o, stall_o
   );

   // Register file side
   modport slave (
      input  rd_addr_i, rd_used_i, wr_en_i, wr_addr_i, wr_data_i, wr_clr_i,
             iss_en_i, iss_rd_i, flush_i,
      output rd_data_o, rd_ready_o, stall_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-priority bypass and a busy scoreboard.
module regfile_mp #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned NRD       = 2,
   parameter int unsigned NWR       = 2,
   parameter int unsigned ZERO_REG  = 1,
   parameter int unsigned BYPASS_EN = 1
) (
   input logic         clk,
   input logic         rest,
   regfile_mp_if.slave bus
);

   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS_EN != 0);

   logic [DATA_W-1:0]   mem_q [NUM_REGS];
   logic [DATA_W-1:0]   mem_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] clr_vec;

   logic [NRD*DATA_W-1:0] rd_data_c;
   logic [NRD-1:0]        rd_ready_c;
   logic                  stall_c;

   // Per-register "final result written this cycle" flags
   always_comb begin
      clr_vec = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         for (int unsigned j = 0; j < NWR; j++) begin
            if (bus.wr_en_i[j] && bus.wr_clr_i[j] &&
                bus.wr_addr_i[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
               clr_vec[r] = 1'b1;
            end
         end
      end
   end

   // Storage next state; ascending port scan lets the later stage win
   always_comb begin
      mem_d = mem_q;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         for (int unsigned j = 0; j < NWR; j++) begin
            if (bus.wr_en_i[j] && bus.wr_addr_i[j*ADDR_W +: ADDR_W] == ADDR_W'(r) &&
                !(ZR && r == 0)) begin
               mem_d[r] = bus.wr_data_i[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Scoreboard next state: flush beats issue, issue beats clear
   always_comb begin
      busy_d = busy_q;
      if (bus.flush_i) begin
         busy_d = '0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (bus.iss_en_i && bus.iss_rd_i == ADDR_W'(r)) begin
               busy_d[r] = 1'b1;
            end else if (clr_vec[r]) begin
               busy_d[r] = 1'b0;
            end
         end
      end
      if (ZR) begin
         busy_d[0] = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            mem_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read ports with forwarding and readiness
   always_comb begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              in_range;
      logic              busy;
      logic              clr;
      rd_data_c  = '0;
      rd_ready_c = '1;
      for (int unsigned k = 0; k < NRD; k++) begin
         a        = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
         d        = '0;
         in_range = 1'b0;
         busy     = 1'b0;
         clr      = 1'b0;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (a == ADDR_W'(r)) begin
               in_range = 1'b1;
               d        = mem_q[r];
               busy     = busy_q[r];
               clr      = clr_vec[r];
            end
         end
         if (BP) begin
            for (int unsigned j = 0; j < NWR; j++) begin
               if (bus.wr_en_i[j] && bus.wr_addr_i[j*ADDR_W +: ADDR_W] == a) begin
                  d = bus.wr_data_i[j*DATA_W +: DATA_W];
               end
            end
         end
         if ((ZR && a == '0) || !in_range) begin
            rd_data_c[k*DATA_W +: DATA_W] = '0;
            rd_ready_c[k]                 = 1'b1;
         end else begin
            rd_data_c[k*DATA_W +: DATA_W] = d;
            rd_ready_c[k]                 = !busy || (BP && clr);
         end
      end
      if (rest) begin
         rd_data_c  = '0;
         rd_ready_c = '1;
      end
   end

   // Stall when any real operand is not ready
   always_comb begin
      stall_c = |(~rd_ready_c & bus.rd_used_i);
   end

   assign bus.rd_data_o  = rd_data_c;
   assign bus.rd_ready_o = rd_ready_c;
   assign bus.stall_o    = stall_c;

endmodule
